// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out shifter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Width of the remaining-bits counter for a given word length.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg_sync_reset_ce_if.sv
// Word-load handshake and serial output bundle.
interface piso_shift_reg_sync_reset_ce_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] D;
    logic             load;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (
        output D, load,
        input  ready, sout, sout_valid, done
    );

    modport slave (
        input  D, load,
        output ready, sout, sout_valid, done
    );
endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter of bits still to be shifted; stops at zero.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; never decrement below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (ce) begin
            if (load) begin
                cnt_d = load_val;
            end else if (dec && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count  = cnt_q;
    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/piso_shift_reg_sync_reset_ce.sv
// Parallel-in serial-out shifter with clock enable, sync reset and gapless reloads.
module piso_shift_reg_sync_reset_ce
    import piso_pkg::*;
#(
    parameter  int unsigned WIDTH     = 4,
    parameter  bit          MSB_FIRST = 1'b1,
    localparam int unsigned CNT_W     = cnt_w(WIDTH)
) (
    input  logic clk,
    input  logic R,
    input  logic CE,
    piso_shift_reg_sync_reset_ce_if.slave bus
);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             done_q, done_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             ready_c;

    logic             first_bit_c;
    logic [WIDTH-1:0] sr_load_c;
    logic             next_bit_c;
    logic [WIDTH-1:0] sr_shift_c;

    // Bit order: the register shifts toward the end that is emitted next.
    always_comb begin
        if (MSB_FIRST) begin
            first_bit_c = bus.D[WIDTH-1];
            sr_load_c   = bus.D << 1;
            next_bit_c  = sr_q[WIDTH-1];
            sr_shift_c  = sr_q << 1;
        end else begin
            first_bit_c = bus.D[0];
            sr_load_c   = bus.D >> 1;
            next_bit_c  = sr_q[0];
            sr_shift_c  = sr_q >> 1;
        end
    end

    assign ready_c = (state_q == IDLE) || ((state_q == SHIFT) && cnt_zero);

    // Next-state and output decode; everything holds while CE is low.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        done_d       = done_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        if (CE) begin
            if (ready_c && bus.load) begin
                state_d      = SHIFT;
                sr_d         = sr_load_c;
                sout_d       = first_bit_c;
                sout_valid_d = 1'b1;
                done_d       = (WIDTH == 1);
                cnt_load     = 1'b1;
            end else if (state_q == SHIFT) begin
                if (cnt_zero) begin
                    state_d      = IDLE;
                    sout_d       = 1'b0;
                    sout_valid_d = 1'b0;
                    done_d       = 1'b0;
                end else begin
                    sr_d    = sr_shift_c;
                    sout_d  = next_bit_c;
                    done_d  = (cnt == CNT_W'(1));
                    cnt_dec = 1'b1;
                end
            end
        end
    end

    // State and output registers; reset overrides CE.
    always_ff @(posedge clk) begin
        if (R) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
        end
    end

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (R),
        .ce       (CE),
        .load     (cnt_load),
        .load_val (CNT_W'(WIDTH - 1)),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero_c   (cnt_zero)
    );

    assign bus.ready      = ready_c;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_shift_reg_sync_reset_ce.sv
// Directed, table-driven bench for the PISO shifter (MSB-first and LSB-first builds).
module tb_piso_shift_reg_sync_reset_ce;

    logic clk;
    logic r_m, ce_m;
    logic r_l, ce_l;

    piso_shift_reg_sync_reset_ce_if #(.WIDTH(4)) bus_m ();
    piso_shift_reg_sync_reset_ce_if #(.WIDTH(4)) bus_l ();

    piso_shift_reg_sync_reset_ce #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .R   (r_m),
        .CE  (ce_m),
        .bus (bus_m)
    );

    piso_shift_reg_sync_reset_ce #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .R   (r_l),
        .CE  (ce_l),
        .bus (bus_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       ce;
        logic       ld;
        logic [3:0] d;
        logic       sout;
        logic       vld;
        logic       dn;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    function automatic void add(input logic r, input logic ce, input logic ld,
                                input logic [3:0] d, input logic s, input logic v,
                                input logic dn, input logic rd);
        vec_t t;
        t.r = r; t.ce = ce; t.ld = ld; t.d = d;
        t.sout = s; t.vld = v; t.dn = dn; t.rdy = rd;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int   cyc;
        logic exp_l[5];

        n_checks = 0;
        n_fail   = 0;
        r_m = 1'b1; ce_m = 1'b0; bus_m.load = 1'b0; bus_m.D = '0;
        r_l = 1'b1; ce_l = 1'b0; bus_l.load = 1'b0; bus_l.D = '0;

        //   R  CE ld D        sout vld done rdy
        add(1, 0, 0, 4'b0000, 0, 0, 0, 1);   // reset
        add(0, 0, 1, 4'b1111, 0, 0, 0, 1);   // load with CE low ignored
        // 1011, then 0110 loaded on its last-bit cycle
        add(0, 1, 1, 4'b1011, 1, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 1, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 1, 1, 1, 1);
        add(0, 1, 1, 4'b0110, 0, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 1, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 1, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 0, 1, 1, 1);
        add(0, 1, 0, 4'b0000, 0, 0, 0, 1);
        add(0, 1, 0, 4'b0000, 0, 0, 0, 1);
        // 1011 with CE pattern 1,0,0,1,...
        add(0, 1, 1, 4'b1011, 1, 1, 0, 0);
        add(0, 0, 0, 4'b0000, 1, 1, 0, 0);
        add(0, 0, 0, 4'b0000, 1, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 0, 1, 0, 0);
        add(0, 0, 0, 4'b0000, 0, 1, 0, 0);
        add(0, 0, 0, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 1, 1, 0, 0);
        add(0, 0, 0, 4'b0000, 1, 1, 0, 0);
        add(0, 0, 0, 4'b0000, 1, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 1, 1, 1, 1);
        add(0, 0, 1, 4'b1111, 1, 1, 1, 1);   // frozen last bit, load ignored
        add(0, 0, 0, 4'b0000, 1, 1, 1, 1);
        add(0, 1, 0, 4'b0000, 0, 0, 0, 1);
        // 1000 with a load of 1111 while busy
        add(0, 1, 1, 4'b1000, 1, 1, 0, 0);
        add(0, 1, 1, 4'b1111, 0, 1, 0, 0);
        add(0, 1, 1, 4'b1111, 0, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 0, 1, 1, 1);
        add(0, 1, 0, 4'b0000, 0, 0, 0, 1);
        // 1010 aborted on its 3rd bit (R beats load), then 0101
        add(0, 1, 1, 4'b1010, 1, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 1, 1, 0, 0);
        add(1, 1, 1, 4'b1111, 0, 0, 0, 1);
        add(0, 1, 1, 4'b0101, 0, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 1, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 0, 4'b0000, 1, 1, 1, 1);
        add(0, 1, 0, 4'b0000, 0, 0, 0, 1);
        // reset with CE low still aborts
        add(0, 1, 1, 4'b1011, 1, 1, 0, 0);
        add(1, 0, 0, 4'b0000, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            r_m        = vecs[i].r;
            ce_m       = vecs[i].ce;
            bus_m.load = vecs[i].ld;
            bus_m.D    = vecs[i].d;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_sout", i),  32'(bus_m.sout),       32'(vecs[i].sout));
            check($sformatf("v%0d_valid", i), 32'(bus_m.sout_valid), 32'(vecs[i].vld));
            check($sformatf("v%0d_done", i),  32'(bus_m.done),       32'(vecs[i].dn));
            check($sformatf("v%0d_ready", i), 32'(bus_m.ready),      32'(vecs[i].rdy));
        end

        // Bounded wait for done after loading 1111: three edges after the load edge.
        r_m = 1'b0; ce_m = 1'b1; bus_m.load = 1'b1; bus_m.D = 4'b1111;
        @(posedge clk);
        #1;
        bus_m.load = 1'b0;
        cyc = 0;
        while (!bus_m.done && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_latency", 32'(cyc), 32'd3);
        check("done_sout", 32'(bus_m.sout), 32'd1);

        // LSB-first build: 0001 -> 1,0,0,0 then idle with sout low.
        @(posedge clk);
        #1;
        check("lsb_reset_ready", 32'(bus_l.ready), 32'd1);
        check("lsb_reset_valid", 32'(bus_l.sout_valid), 32'd0);
        r_l = 1'b0; ce_l = 1'b1; bus_l.D = 4'b0001; bus_l.load = 1'b1;
        exp_l = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            bus_l.load = 1'b0;
            check($sformatf("lsb_b%0d_sout", k),  32'(bus_l.sout),       32'(exp_l[k]));
            check($sformatf("lsb_b%0d_valid", k), 32'(bus_l.sout_valid), (k < 4) ? 32'd1 : 32'd0);
            check($sformatf("lsb_b%0d_done", k),  32'(bus_l.done),       (k == 3) ? 32'd1 : 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
